// File: rtl/bp_fe_pc_gen_mt.sv
// Multi-threaded next-PC generator: per-thread PC/ghist, round-robin
// IF0 select, thread-tagged IF1/IF2 slots, per-thread redirect/override.
// Ports:
//   clk_i, reset_i            clock, async active-high reset
//   stall_i                   per-thread hold (1 = ineligible)
//   next_v/tid/pc/ghist_o     IF0 selection
//   if1_we_i, if2_we_i        load IF1 slot / advance IF1 into IF2
//   pred_taken/tgt/br_i       predictor result for the IF1 entry
//   if1_v/tid/pc_o            IF1 slot
//   if2_v/tid/pc_o            IF2 slot
//   ovr_v_i, ovr_tgt_i        IF2 override for thread if2_tid_o
//   redirect_*_i              backend redirect (thread, PC, history)
module bp_fe_pc_gen_mt #(
  parameter int vaddr_width_p = 39,
  parameter int threads_p = 2,
  parameter int tid_width_p = (threads_p > 1) ? $clog2(threads_p) : 1,
  parameter int fetch_bytes_p = 4,
  parameter int ghist_width_p = 2,
  parameter logic [vaddr_width_p-1:0] reset_pc_p = vaddr_width_p'('h80000000)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [threads_p-1:0]     stall_i,
  output logic                     next_v_o,
  output logic [tid_width_p-1:0]   next_tid_o,
  output logic [vaddr_width_p-1:0] next_pc_o,
  output logic [ghist_width_p-1:0] next_ghist_o,
  input  logic                     if1_we_i,
  input  logic                     if2_we_i,
  input  logic                     pred_taken_i,
  input  logic [vaddr_width_p-1:0] pred_tgt_i,
  input  logic                     pred_br_i,
  output logic                     if1_v_o,
  output logic [tid_width_p-1:0]   if1_tid_o,
  output logic [vaddr_width_p-1:0] if1_pc_o,
  output logic                     if2_v_o,
  output logic [tid_width_p-1:0]   if2_tid_o,
  output logic [vaddr_width_p-1:0] if2_pc_o,
  input  logic                     ovr_v_i,
  input  logic [vaddr_width_p-1:0] ovr_tgt_i,
  input  logic                     redirect_v_i,
  input  logic [tid_width_p-1:0]   redirect_tid_i,
  input  logic [vaddr_width_p-1:0] redirect_npc_i,
  input  logic [ghist_width_p-1:0] redirect_ghist_i
);

  localparam logic [vaddr_width_p-1:0] FB_MASK =
    vaddr_width_p'(fetch_bytes_p - 1);
  localparam logic [vaddr_width_p-1:0] FB_SIZE =
    vaddr_width_p'(fetch_bytes_p);

  logic [vaddr_width_p-1:0] pc_q    [threads_p];
  logic [vaddr_width_p-1:0] pc_d    [threads_p];
  logic [ghist_width_p-1:0] ghist_q [threads_p];
  logic [ghist_width_p-1:0] ghist_d [threads_p];
  logic [threads_p-1:0]     busy_q, busy_d;
  logic [tid_width_p-1:0]   rr_last_q;

  logic                     if1_v_q, if2_v_q;
  logic [tid_width_p-1:0]   if1_tid_q, if2_tid_q;
  logic [vaddr_width_p-1:0] if1_pc_q, if2_pc_q;

  logic [threads_p-1:0]     redir_hit, ovr_hit, elig;
  logic [tid_width_p-1:0]   sel;
  logic                     found;
  logic                     launch, ovr_act, if1_kill, if2_redir, adv;
  logic [vaddr_width_p-1:0] seq_pc, adv_pc;
  int                       idx;

  always_comb begin
    for (int t = 0; t < threads_p; t++) begin
      redir_hit[t] = redirect_v_i
                   & (redirect_tid_i == tid_width_p'(t));
      ovr_hit[t]   = ovr_v_i & if2_v_q
                   & (if2_tid_q == tid_width_p'(t));
      elig[t]      = ~stall_i[t] & ~busy_q[t]
                   & ~redir_hit[t] & ~ovr_hit[t];
    end
  end

  // Round-robin: scan from the thread after the last launcher.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= threads_p; i++) begin
      idx = (int'(rr_last_q) + i) % threads_p;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = tid_width_p'(idx);
      end
    end
  end

  assign next_v_o     = found;
  assign next_tid_o   = sel;
  assign next_pc_o    = pc_q[sel];
  assign next_ghist_o = ghist_q[sel];

  assign launch    = if1_we_i & found;
  // A redirect to the IF2 thread suppresses its override.
  assign if2_redir = redirect_v_i & (redirect_tid_i == if2_tid_q);
  assign ovr_act   = ovr_v_i & if2_v_q & ~if2_redir;
  assign if1_kill  = if1_v_q
    & ((redirect_v_i & (redirect_tid_i == if1_tid_q))
     | (ovr_act & (if2_tid_q == if1_tid_q)));
  assign adv       = if2_we_i & if1_v_q & ~if1_kill;

  assign seq_pc = (if1_pc_q & ~FB_MASK) + FB_SIZE;
  assign adv_pc = pred_taken_i ? pred_tgt_i : seq_pc;

  // Per-thread state; later assignments win: redirect > ovr > advance.
  always_comb begin
    busy_d = busy_q;
    for (int t = 0; t < threads_p; t++) begin
      pc_d[t]    = pc_q[t];
      ghist_d[t] = ghist_q[t];
      if (adv && if1_tid_q == tid_width_p'(t)) begin
        pc_d[t]   = adv_pc;
        busy_d[t] = 1'b0;
        if (pred_br_i)
          ghist_d[t] = ghist_width_p'({ghist_q[t], pred_taken_i});
      end
      if (launch && sel == tid_width_p'(t))
        busy_d[t] = 1'b1;
      if (ovr_act && if2_tid_q == tid_width_p'(t)) begin
        pc_d[t]   = ovr_tgt_i;
        busy_d[t] = 1'b0;
      end
      if (redir_hit[t]) begin
        pc_d[t]    = redirect_npc_i;
        ghist_d[t] = redirect_ghist_i;
        busy_d[t]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int t = 0; t < threads_p; t++) begin
        pc_q[t]    <= reset_pc_p;
        ghist_q[t] <= '0;
      end
      busy_q    <= '0;
      rr_last_q <= tid_width_p'(threads_p - 1);
      if1_v_q   <= 1'b0;
      if1_tid_q <= '0;
      if1_pc_q  <= '0;
      if2_v_q   <= 1'b0;
      if2_tid_q <= '0;
      if2_pc_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      ghist_q <= ghist_d;
      busy_q  <= busy_d;
      if (launch)
        rr_last_q <= sel;
      if (if1_we_i) begin
        if1_v_q <= launch;
        if (launch) begin
          if1_tid_q <= sel;
          if1_pc_q  <= pc_q[sel];
        end
      end else if (if2_we_i) begin
        if1_v_q <= 1'b0;
      end else begin
        if1_v_q <= if1_v_q & ~if1_kill;
      end
      if (if2_we_i) begin
        if2_v_q   <= if1_v_q & ~if1_kill;
        if2_tid_q <= if1_tid_q;
        if2_pc_q  <= if1_pc_q;
      end else begin
        if2_v_q <= if2_v_q & ~if2_redir;
      end
    end
  end

  assign if1_v_o   = if1_v_q;
  assign if1_tid_o = if1_tid_q;
  assign if1_pc_o  = if1_pc_q;
  assign if2_v_o   = if2_v_q;
  assign if2_tid_o = if2_tid_q;
  assign if2_pc_o  = if2_pc_q;

  // Loading IF1 while it still holds an unadvanced entry drops it.
  a_if1_overwrite: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(if1_we_i && if1_v_q && !if2_we_i));

endmodule
